end_scene_mixer: RTL and testbench
==================================

END_SCENE_MIXER -- requirements
Module: end_scene_mixer

Interface
REQ-001 The block SHALL have parameter FADE_STEP, default 2, meaning frames per alpha step (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  pixel-rate system clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port frame_start  input  1  one-cycle pulse at the first cycle of each frame.
REQ-005 The block SHALL have port video_on  input  1  visible-area flag, aligned with col/row (cycle N).
REQ-006 The block SHALL have port base_rgb  input  12  game-layer pixel {R,G,B}, 4 bits each, aligned with col/row (cycle N).
REQ-007 The block SHALL have port game_over  input  1  level; player has died.
REQ-008 The block SHALL have port restart  input  1  one-cycle pulse; player requested restart.
REQ-009 The block SHALL have port is_end_scene  input  1  overlay-pixel-opaque flag, valid at cycle N+1 (ROM latency).
REQ-010 The block SHALL have port end_scene_rgb  input  12  overlay pixel, valid at cycle N+1.
REQ-011 The block SHALL have port vga_rgb  output  12  composited pixel, valid at cycle N+2.
REQ-012 The block SHALL have port fade_state  output  2  current state encoding (IDLE=0, FADE_IN=1, HOLD=2, FADE_OUT=3).
REQ-013 The block SHALL have port restart_done  output  1  one-cycle pulse when FADE_OUT reaches alpha 0.

Function
REQ-014 The block SHALL delay video_on and base_rgb by one register stage so they align with is_end_scene/end_scene_rgb at N+1.
REQ-015 The block SHALL register the blended result so vga_rgb has fixed latency of 2 cycles from col/row.
REQ-016 The block SHALL hold a 5-bit alpha in 0..16 and a 4-bit frame counter.
REQ-017 Per channel, for overlay pixels (is_end_scene=1): out = (ov*alpha + base*(16-alpha)) >> 4, 9-bit intermediate, result 4 bits, no saturation needed.
REQ-018 For non-overlay pixels, out SHALL equal delayed base_rgb (subject to REQ-030).
REQ-019 When delayed video_on=0, vga_rgb SHALL be 12'h000 regardless of state.
REQ-020 IDLE: alpha=0; game_over=1 -> FADE_IN on next cycle.
REQ-021 FADE_IN: on each frame_start, frame counter increments; when it reaches FADE_STEP-1 it clears and alpha increments by 1; at alpha=16 -> HOLD.
REQ-022 HOLD: alpha=16; restart=1 -> FADE_OUT.
REQ-023 FADE_OUT: same frame pacing, alpha decrements; on reaching 0 -> IDLE with restart_done pulsed for exactly one cycle.
REQ-024 restart in FADE_IN SHALL go to FADE_OUT keeping current alpha; game_over=1 in FADE_OUT SHALL go to FADE_IN keeping current alpha; restart has priority if both asserted same cycle.
REQ-025 Frame counter SHALL clear on every state change; alpha SHALL change only on a frame_start cycle (no mid-frame tearing).
REQ-026 restart in IDLE and game_over in HOLD SHALL be ignored; alpha SHALL never wrap below 0 or above 16.

Reset
REQ-027 On rst=1 at a clk edge: state IDLE, alpha 0, frame counter 0, pipeline registers 0, vga_rgb 12'h000, restart_done 0.
REQ-028 Reset mid-fade SHALL abandon the fade immediately; no restart_done pulse is produced.
REQ-029 rst SHALL take priority over all other inputs.

Configuration
REQ-030 With DIM_BACKGROUND_EN defined, non-overlay pixels SHALL be out = (base*(32-alpha)) >> 5 per channel (half brightness at alpha 16); without it, non-overlay pixels pass unchanged.

Verification
REQ-031 Reset: rst high 3 cycles, base_rgb=12'hFFF, video_on=1 -> vga_rgb=12'h000, fade_state=0 throughout and first cycle after.
REQ-032 Latency: IDLE, base_rgb=12'h5A3 at cycle N, video_on=1 -> vga_rgb=12'h5A3 at N+2; video_on=0 -> 12'h000.
REQ-033 Fade pacing: FADE_STEP=2, game_over=1, frame_start every 100 cycles -> alpha 16 and fade_state=2 after 32 frame_starts; overlay 12'hF00 over base 12'h00F at alpha 8 -> 12'h707.
REQ-034 Reversal: restart pulse at alpha 6 in FADE_IN -> fade_state=3, alpha 5 after FADE_STEP frames, restart_done once at alpha 0, then fade_state=0.
REQ-035 Simultaneous: restart and game_over both high in FADE_IN -> FADE_OUT; restart in IDLE -> no change.
REQ-036 With DIM_BACKGROUND_EN: HOLD, is_end_scene=0, base 12'hFFF -> vga_rgb 12'h777; without -> 12'hFFF.

Source files
------------

// File: rtl/end_scene_mixer.sv
// End-of-game overlay compositor: fades an overlay in over the game layer and back out on restart.
// Optional build macro DIM_BACKGROUND_EN dims non-overlay pixels as the overlay fades in.
module end_scene_mixer #(
  parameter int FADE_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        video_on,
  input  logic [11:0] base_rgb,
  input  logic        game_over,
  input  logic        restart,
  input  logic        is_end_scene,
  input  logic [11:0] end_scene_rgb,
  output logic [11:0] vga_rgb,
  output logic [1:0]  fade_state,
  output logic        restart_done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  alpha_q, alpha_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        done_q, done_d;
  logic        step_tick;

  logic        vld_p1_q;
  logic [11:0] base_p1_q;
  logic [11:0] rgb_p2_q, rgb_p2_d;

  function automatic logic [3:0] blend_ch(input logic [3:0] ov, input logic [3:0] bs,
                                          input logic [4:0] a);
    logic [8:0] acc;
    acc = ({5'd0, ov} * {4'd0, a}) + ({5'd0, bs} * {4'd0, 5'd16 - a});
    return 4'(acc >> 4);
  endfunction

  function automatic logic [11:0] blend_px(input logic [11:0] ov, input logic [11:0] bs,
                                           input logic [4:0] a);
    return {blend_ch(ov[11:8], bs[11:8], a), blend_ch(ov[7:4], bs[7:4], a),
            blend_ch(ov[3:0], bs[3:0], a)};
  endfunction

`ifdef DIM_BACKGROUND_EN
  function automatic logic [3:0] dim_ch(input logic [3:0] bs, input logic [4:0] a);
    logic [8:0] acc;
    acc = {5'd0, bs} * (9'd32 - {4'd0, a});
    return 4'(acc >> 5);
  endfunction

  function automatic logic [11:0] background_px(input logic [11:0] bs, input logic [4:0] a);
    return {dim_ch(bs[11:8], a), dim_ch(bs[7:4], a), dim_ch(bs[3:0], a)};
  endfunction
`else
  function automatic logic [11:0] background_px(input logic [11:0] bs, input logic [4:0] a);
    return (a == 5'd31) ? bs : bs;
  endfunction
`endif

  // Alpha moves one step per FADE_STEP frames, only on a frame_start cycle.
  assign step_tick = frame_start && (fcnt_q == 4'(FADE_STEP - 1));

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        alpha_d = 5'd0;
        if (game_over) state_d = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (restart) begin
          state_d = ST_FADE_OUT;
        end else if (alpha_q == 5'd16) begin
          state_d = ST_HOLD;
        end else if (step_tick) begin
          fcnt_d  = 4'd0;
          alpha_d = alpha_q + 5'd1;
          if (alpha_q == 5'd15) state_d = ST_HOLD;
        end else if (frame_start) begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        if (restart) state_d = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (game_over && !restart) begin
          state_d = ST_FADE_IN;
        end else if (alpha_q == 5'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (step_tick) begin
          fcnt_d  = 4'd0;
          alpha_d = alpha_q - 5'd1;
          if (alpha_q == 5'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (frame_start) begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) fcnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      alpha_q <= 5'd0;
      fcnt_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  // p1: align game layer with the overlay ROM output
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      base_p1_q <= 12'h000;
    end else begin
      vld_p1_q  <= video_on;
      base_p1_q <= base_rgb;
    end
  end

  always_comb begin
    rgb_p2_d = 12'h000;
    if (vld_p1_q) begin
      if (is_end_scene) rgb_p2_d = blend_px(end_scene_rgb, base_p1_q, alpha_q);
      else              rgb_p2_d = background_px(base_p1_q, alpha_q);
    end
  end

  // p2: composited output register
  always_ff @(posedge clk) begin
    if (rst) rgb_p2_q <= 12'h000;
    else     rgb_p2_q <= rgb_p2_d;
  end

  assign vga_rgb      = rgb_p2_q;
  assign fade_state   = state_q;
  assign restart_done = done_q;

endmodule

// File: tb/tb_end_scene_mixer.sv
// Scoreboard bench for end_scene_mixer: random pixels and control against a frame-level fade model.
module tb_end_scene_mixer;
  localparam int STEP = 2;

  logic        clk = 1'b1;
  logic        rst = 1'b0, frame_start = 1'b0, video_on = 1'b0;
  logic        game_over = 1'b0, restart = 1'b0, is_end_scene = 1'b0;
  logic [11:0] base_rgb = 12'h000, end_scene_rgb = 12'h000;
  logic [11:0] vga_rgb;
  logic [1:0]  fade_state;
  logic        restart_done;

  always #5 clk = ~clk;

  end_scene_mixer #(.FADE_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .video_on(video_on),
    .base_rgb(base_rgb), .game_over(game_over), .restart(restart),
    .is_end_scene(is_end_scene), .end_scene_rgb(end_scene_rgb),
    .vga_rgb(vga_rgb), .fade_state(fade_state), .restart_done(restart_done)
  );

  typedef struct {
    logic [11:0] rgb;
    logic [1:0]  st;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 fading in, 2 holding, 3 fading out; frames counted since last alpha step.
  int          m_st = 0, m_a = 0, m_frames = 0;
  bit          m_done = 0;
  bit          m_pvid = 0;
  logic [11:0] m_pbase = 12'h000;
  int          cyc = 0, fper = 20;

  function automatic logic [11:0] ref_pixel(input bit vid, input logic [11:0] b, input bit ov,
                                            input logic [11:0] o, input int a);
    logic [11:0] r;
    int bc, oc;
    r = 12'h000;
    if (!vid) return r;
    for (int c = 0; c < 3; c++) begin
      bc = int'(b[c*4 +: 4]);
      oc = int'(o[c*4 +: 4]);
      if (ov) r[c*4 +: 4] = 4'((oc * a + bc * (16 - a)) / 16);
`ifdef DIM_BACKGROUND_EN
      else    r[c*4 +: 4] = 4'((bc * (32 - a)) / 32);
`else
      else    r[c*4 +: 4] = 4'(bc);
`endif
    end
    return r;
  endfunction

  task automatic model_update(input bit r, input bit go, input bit rs, input bit fs);
    m_done = 0;
    if (r) begin
      m_st = 0; m_a = 0; m_frames = 0;
    end else if (m_st == 0) begin
      if (go) begin m_st = 1; m_frames = 0; end
    end else if (m_st == 1) begin
      if (rs) begin m_st = 3; m_frames = 0; end
      else if (m_a >= 16) begin m_st = 2; m_frames = 0; end
      else if (fs) begin
        m_frames++;
        if (m_frames == STEP) begin
          m_frames = 0; m_a++;
          if (m_a == 16) m_st = 2;
        end
      end
    end else if (m_st == 2) begin
      if (rs) begin m_st = 3; m_frames = 0; end
    end else begin
      if (go && !rs) begin m_st = 1; m_frames = 0; end
      else if (m_a <= 0) begin m_st = 0; m_frames = 0; m_done = 1; end
      else if (fs) begin
        m_frames++;
        if (m_frames == STEP) begin
          m_frames = 0; m_a--;
          if (m_a == 0) begin m_st = 0; m_done = 1; end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit go, input bit rs, input bit vid,
                       input logic [11:0] b, input bit ov, input logic [11:0] o);
    bit   fs;
    exp_t e;
    @(negedge clk);
    fs = (cyc % fper) == 0;
    cyc++;
    rst = r; game_over = go; restart = rs; frame_start = fs;
    video_on = vid; base_rgb = b; is_end_scene = ov; end_scene_rgb = o;
    e.rgb = r ? 12'h000 : ref_pixel(m_pvid, m_pbase, ov, o, m_a);
    m_pvid  = r ? 1'b0 : vid;
    m_pbase = r ? 12'h000 : b;
    model_update(r, go, rs, fs);
    e.st   = 2'(m_st);
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic drive_rand(input bit r, input bit go, input bit rs);
    drive(r, go, rs, $urandom_range(0, 9) != 0, 12'($urandom), $urandom_range(0, 1) == 1,
          12'($urandom));
  endtask

  task automatic run_until(input int st, input int a, input bit go, input string what);
    int n;
    n = 0;
    while (!(m_st == st && (a < 0 || m_a == a)) && n < 5000) begin
      drive_rand(0, go, 0);
      n++;
    end
    if (!(m_st == st && (a < 0 || m_a == a))) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: model at phase %0d alpha %0d, wanted phase %0d alpha %0d",
               what, m_st, m_a, st, a);
    end
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("vga_rgb", vga_rgb, e.rgb);
      chk("fade_state", 12'(fade_state), 12'(e.st));
      chk("restart_done", 12'(restart_done), 12'(e.done));
    end
  end

  initial begin
    repeat (3) drive(1, 0, 0, 1, 12'hFFF, 0, 12'h000);
    drive(0, 0, 0, 1, 12'h5A3, 0, 12'h000);
    drive(0, 0, 0, 0, 12'h5A3, 0, 12'h000);
    drive(0, 0, 0, 0, 12'hFFF, 1, 12'hFFF);
    drive(0, 0, 0, 1, 12'h000, 0, 12'h000);
    repeat (40) drive_rand(0, 0, $urandom_range(0, 7) == 0);

    run_until(1, 8, 1, "fade-in to alpha 8");
    repeat (2) drive(0, 1, 0, 1, 12'h00F, 1, 12'hF00);
    run_until(2, -1, 1, "hold");
    repeat (2) drive(0, 1, 0, 1, 12'hFFF, 0, 12'h000);
    drive_rand(0, 0, 1);
    run_until(0, -1, 0, "fade-out to idle");

    drive_rand(0, 1, 0);
    run_until(1, 6, 0, "fade-in to alpha 6");
    drive_rand(0, 0, 1);
    run_until(3, 5, 0, "reversed fade-out to alpha 5");
    drive_rand(0, 1, 0);
    repeat (5) drive_rand(0, 0, 0);
    drive_rand(0, 1, 1);
    run_until(0, -1, 0, "idle after simultaneous request");
    repeat (10) drive_rand(0, 0, 1);

    drive_rand(0, 1, 0);
    run_until(1, 3, 0, "fade-in to alpha 3");
    repeat (2) drive_rand(1, 0, 0);
    repeat (20) drive_rand(0, 0, 0);

    fper = 3;
    repeat (3000) drive_rand($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
                            $urandom_range(0, 59) == 0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 12'(sb.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
